// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, state and queue entry types for the fetch front end
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;
    typedef enum logic {RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order FIFO of fetched {pc, instr} pairs with single-cycle flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [AW:0]  count,
    output logic         valid,
    output fetch_entry_t head
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic take;
    assign valid = count != '0;
    assign take = pop && valid;
    // head reads as zero when empty so the decode payload idles at its reset value
    assign head = valid ? mem[rd] : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (take) rd <= rd + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(take);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding instruction memory and a decode queue,
// with redirect handling and halt on zero word or PC past the end of memory.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int MEM_BYTES = 1024,
    parameter int QDEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               imem_stop,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [XLEN-1:0]    dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic               halted
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);
    fetch_state_t state;
    logic resp_pending;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0] count;
    logic [CW:0] occ;
    logic in_range, issue, stop, push;
    fetch_entry_t head;
    // queued plus in-flight entries must fit, so a response never meets a full queue
    assign occ = {1'b0, count} + {{CW{1'b0}}, resp_pending};
    assign in_range = pc <= LAST_PC;
    assign issue = state == RUN && !redirect_valid && occ < QD && in_range;
    assign stop = resp_pending && imem_stop;
    assign push = resp_pending && !imem_stop && !redirect_valid;
    assign halted = state == HALT;
    assign dec_pc = head.pc;
    assign dec_instr = head.instr;
    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(dec_ready),
        .flush(redirect_valid),
        .din('{pc: resp_pc, instr: imem_instr}),
        .count(count),
        .valid(dec_valid),
        .head(head)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            resp_pending <= 1'b0;
            resp_pc <= '0;
        end else if (redirect_valid) begin
            state <= RUN;
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
            resp_pending <= 1'b0;
        end else if (stop) begin
            state <= HALT;
            pc <= resp_pc;
            resp_pending <= 1'b0;
        end else begin
            resp_pending <= issue;
            if (issue) begin
                resp_pc <= pc;
                pc <= pc + XLEN'(4);
            end
            if (state == RUN && !in_range) state <= HALT;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan scenarios plus randomized run against a queue-based reference model
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int MEM_BYTES = 1024;
    localparam int QDEPTH = 4;
    localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] pc, imem_instr, redirect_pc, dec_pc, dec_instr;
    logic imem_stop, redirect_valid, dec_valid, dec_ready, halted;
    int passed = 0, total = 0;
    logic [31:0] mem [256];

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_instr(imem_instr), .imem_stop(imem_stop),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_instr(dec_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a < MEM_BYTES ? mem[a[9:2]] : 32'h0;
    endfunction

    // instruction memory: registered read of the PC presented at each edge
    initial forever begin
        @(posedge clk);
        imem_instr <= word(pc);
        imem_stop <= word(pc) == 32'h0;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h want %h", n, a, e);
        else passed++;
    endtask

    // reference model: queue of expected decode entries, one outstanding fetch
    fetch_entry_t mq[$];
    logic [31:0] m_pc = 0, m_rpc = 0;
    bit m_pend = 0, m_halt = 0;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_pc = 0; m_rpc = 0; m_pend = 0; m_halt = 0;
        end else begin
            automatic bit fire = !m_halt && !redirect_valid && (mq.size() + int'(m_pend) < QDEPTH) && m_pc <= LAST;
            automatic logic [31:0] w = word(m_rpc);
            automatic bit stp = m_pend && w == 0;
            if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_pend = 0; m_halt = 0;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (stp) begin
                m_halt = 1; m_pend = 0; m_pc = m_rpc;
            end else begin
                if (m_pend) mq.push_back('{pc: m_rpc, instr: w});
                if (fire) begin
                    m_rpc = m_pc; m_pc += 4; m_pend = 1;
                end else begin
                    m_pend = 0;
                    if (m_pc > LAST) m_halt = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_pc", pc, m_pc);
            chk("m_halted", 32'(halted), 32'(m_halt));
            chk("m_dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_dec_pc", dec_pc, mq[0].pc);
                chk("m_dec_instr", dec_instr, mq[0].instr);
            end
        end
    end

    task automatic fill();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    endtask
    task automatic rst_on();
        #1 rst = 1'b1;
    endtask
    task automatic rst_off();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc = t;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask
    task automatic collect(input int want, output logic [31:0] got [$]);
        got.delete();
        for (int i = 0; i < 20 && got.size() < want; i++) begin
            if (dec_valid && dec_ready) got.push_back(dec_pc);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] got [$];
        logic [31:0] bp_exp [5];
        redirect_valid = 0; redirect_pc = 0; dec_ready = 1;
        // straight line
        rst_on(); fill(); mem[0] = 32'h0050_0093; mem[1] = 32'h0010_8113; mem[2] = 0; rst_off();
        chk("sl_pc_c0", pc, 32'h0);
        repeat (2) @(negedge clk);
        chk("sl_valid_c2", 32'(dec_valid), 1);
        chk("sl_pc_c2", dec_pc, 32'h0);
        chk("sl_instr_c2", dec_instr, 32'h0050_0093);
        @(negedge clk);
        chk("sl_pc_c3", dec_pc, 32'h4);
        chk("sl_instr_c3", dec_instr, 32'h0010_8113);
        @(negedge clk);
        chk("sl_halted_c4", 32'(halted), 1);
        chk("sl_fetchpc_c4", pc, 32'h8);
        chk("sl_novalid_c4", 32'(dec_valid), 0);
        // halt recovery
        redirect(32'h0);
        chk("hr_halted", 32'(halted), 0);
        chk("hr_pc", pc, 32'h0);
        @(negedge clk);
        chk("hr_pc_next", pc, 32'h4);
        // backpressure
        rst_on(); fill(); dec_ready = 0; rst_off();
        repeat (4) @(negedge clk);
        chk("bp_pc_c4", pc, 32'h10);
        repeat (2) @(negedge clk);
        chk("bp_pc_c6", pc, 32'h10);
        chk("bp_head_c6", dec_pc, 32'h0);
        dec_ready = 1;
        collect(5, got);
        bp_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        chk("bp_count", 32'(got.size()), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("bp_order%0d", i), got[i], bp_exp[i]);
        // redirect with three entries queued and one in flight
        rst_on(); fill(); dec_ready = 0; rst_off();
        repeat (4) @(negedge clk);
        chk("rd_valid_r", 32'(dec_valid), 1);
        redirect(32'h40);
        chk("rd_valid_r1", 32'(dec_valid), 0);
        chk("rd_pc_r1", pc, 32'h40);
        repeat (2) @(negedge clk);
        chk("rd_valid_r3", 32'(dec_valid), 1);
        chk("rd_pc_r3", dec_pc, 32'h40);
        chk("rd_instr_r3", dec_instr, 32'hA000_0010);
        dec_ready = 1;
        collect(2, got);
        chk("rd_count", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("rd_first", got[0], 32'h40);
            chk("rd_second", got[1], 32'h44);
        end
        // alignment and range
        dec_ready = 0;
        redirect(32'h3FE);
        chk("al_pc", pc, 32'h3FC);
        @(negedge clk);
        chk("al_pc_end", pc, 32'h400);
        @(negedge clk);
        chk("al_dec_pc", dec_pc, 32'h3FC);
        chk("al_halted", 32'(halted), 1);
        redirect(32'h400);
        chk("rg_pc", pc, 32'h400);
        chk("rg_valid_r1", 32'(dec_valid), 0);
        chk("rg_halted_r1", 32'(halted), 0);
        @(negedge clk);
        chk("rg_halted_r2", 32'(halted), 1);
        chk("rg_valid_r2", 32'(dec_valid), 0);
        // reset mid-stream with a full queue
        redirect(32'h0);
        repeat (5) @(negedge clk);
        chk("rs_full_pc", pc, 32'h10);
        chk("rs_full_valid", 32'(dec_valid), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rs_pc", pc, 32'h0);
        chk("rs_valid", 32'(dec_valid), 0);
        chk("rs_dec_pc", dec_pc, 32'h0);
        chk("rs_dec_instr", dec_instr, 32'h0);
        chk("rs_halted", 32'(halted), 0);
        rst_off();
        chk("rs_pc_c0", pc, 32'h0);
        repeat (2) @(negedge clk);
        chk("rs_dec_pc_c2", dec_pc, 32'h0);
        chk("rs_valid_c2", 32'(dec_valid), 1);
        // randomized run
        rst_on();
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
        rst_off();
        for (int c = 0; c < 4000; c++) begin
            dec_ready = $urandom_range(0, 3) != 0;
            redirect_valid = halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom_range(0, 1055);
            if (c == 2000) begin
                redirect_valid = 0;
                rst_on();
                rst_off();
            end else @(negedge clk);
        end
        redirect_valid = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch sequencer that drives the byte-address PC into the instruction memory and consumes its registered `instr`/`stop` response. It buffers fetched words in a small in-order queue and hands `{pc, instr}` pairs to decode over a valid/ready handshake. It also handles branch/flush redirects and halts the front end when memory reports a zero word or the PC leaves the memory range.

## Interface
- `RESET_PC`, default 32'h0: PC fetched first after reset.
- `MEM_BYTES`, default 1024: instruction memory size in bytes.
- `QDEPTH`, default 4: fetch queue entries (power of two, ≥2).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `pc`  out  32: fetch address to instruction memory; the memory samples it on each rising edge.
- `imem_instr`  in  32: memory word for the PC sampled at the previous edge.
- `imem_stop`  in  1: memory flag; the fetched word is all-zero (end of program).
- `redirect_valid`  in  1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: redirect target.
- `dec_valid`  out  1: queue head valid.
- `dec_ready`  in  1: decode accepts the head this cycle.
- `dec_pc`  out  32: PC of the head entry.
- `dec_instr`  out  32: instruction of the head entry.
- `halted`  out  1: front end in HALT state.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Issue (RUN only): a fetch issues this cycle when `count + resp_pending < QDEPTH`, no redirect is present, and `pc <= MEM_BYTES-4`.
  - At the edge: `resp_pending<=1`, `resp_pc<=pc`, `pc<=pc+4`.
  - When no fetch issues: `resp_pending<=0`; `pc` holds.
- Response: when `resp_pending` and `imem_stop==0`, enqueue `{resp_pc, imem_instr}` at the edge.
- Stop: when `resp_pending` and `imem_stop==1`, do not enqueue.
  - Go to HALT, set `pc<=resp_pc`, `resp_pending<=0`. Any fetch issued in the same cycle is discarded.
- Range: in RUN with `pc > MEM_BYTES-4`, go to HALT without issuing; `pc` holds.
- HALT: no issue. Queue entries still drain to decode. Leave only via redirect or reset.
- Redirect (highest priority, any state):
  - At the edge: queue cleared, `resp_pending<=0` (response in flight dropped), `pc<={redirect_pc[31:2],2'b00}`, state RUN.
  - No issue in the redirect cycle. A dequeue in the same cycle is still a completed transfer.
- Decode handshake: transfer when `dec_valid && dec_ready`. Head payload stays stable while `dec_valid && !dec_ready`.
- Simultaneous enqueue and dequeue: `count` unchanged. The issue rule guarantees no enqueue when full.
- Pointers wrap modulo `QDEPTH`. `count` is `clog2(QDEPTH)+1` bits wide.

## Timing
- Reset values: `pc=RESET_PC`, `dec_valid=0`, `dec_pc=0`, `dec_instr=0`, `halted=0`, queue empty, `resp_pending=0`.
- PC issued in cycle n: response in cycle n+1, earliest `dec_valid` in cycle n+2.
- Throughput: 1 instruction/cycle with `dec_ready` held high.
- `halted` rises the cycle after the stop response or the out-of-range detection.
- Redirect in cycle r:
  - `dec_valid=0` in r+1.
  - `pc_o=target` issued in r+1.
  - First new `dec_valid` in r+3.
- `rst` asserted mid-operation clears all state immediately. First issue of `RESET_PC` occurs in the first cycle after deassertion.

## Structure
- Shared package `fetch_pkg`: `INSTR_W`=32, `XLEN`=32, `fetch_state_t` {RUN, HALT}, `fetch_entry_t` {pc, instr}, default `RESET_PC`.
- One sub-module, `fetch_queue`: synchronous FIFO of `fetch_entry_t`, depth `QDEPTH`.
  - Ports: `push`, `pop`, `flush`, `count`, head outputs.
  - Same clock and asynchronous active-high reset as the parent.
- The parent holds the PC, response tracking, issue rule and state register.

## Test plan
- Straight line:
  - Stimulus: memory 0x00500093@0, 0x00108113@4, 0@8; `dec_ready=1`.
  - Required: `dec_valid` with pc 0 in cycle 2 and pc 4 in cycle 3; `halted=1` in cycle 4 with `pc=8`; no entry for pc 8.
- Backpressure:
  - Stimulus: `dec_ready=0`.
  - Required: `pc` stalls at 0x10 from cycle 4 with 4 entries queued. After releasing `dec_ready`, decode sees pcs 0,4,8,0xC,0x10 in order with no loss or duplicate.
- Redirect:
  - Stimulus: `redirect_pc=0x40` in cycle r with 3 entries queued.
  - Required: `dec_valid=0` in r+1, next `dec_pc=0x40` in r+3, the pre-redirect response is never delivered.
- Halt recovery:
  - Stimulus: reach HALT, then redirect to 0x0.
  - Required: `halted=0` the next cycle, fetch resumes at 0x0.
- Alignment and range:
  - Stimulus A: redirect to 0x3FE.
  - Required A: fetch at 0x3FC.
  - Stimulus B: redirect to 0x400.
  - Required B: no entry enqueued, `halted=1` two cycles later.
- Reset mid-stream:
  - Stimulus: assert `rst` between edges while the queue is full.
  - Required: outputs take reset values asynchronously; first fetch after release is `RESET_PC`.
